id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decode outputs (sign-extended immediate, operands, register addresses, control bundle, branch-predictor metadata) and presents them to EX one cycle later.
- Implements stall hold, flush-to-bubble, and write-back refresh of held operands so a stalled instruction never carries stale register data.

Parameters:
- XLEN, 32, datapath width.
- PHT_IDX_W, 10, agree-predictor PHT index width carried for update in EX.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold current contents (from hazard unit)
- i_flush  in  1  replace contents with bubble (mispredict/load-use)
- i_valid  in  1  ID holds a real instruction
- i_pc  in  XLEN  instruction PC
- i_rs1_data  in  XLEN  register-file read port 1
- i_rs2_data  in  XLEN  register-file read port 2
- i_imm  in  XLEN  immediate from decode immediate generator
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  5 each  register indices
- i_ctrl  in  $bits(ctrl_t)  decoded control bundle
- i_pred_taken  in  1  predictor direction
- i_pred_target  in  XLEN  predicted target
- i_pht_idx  in  PHT_IDX_W  PHT index used at fetch
- i_wb_we  in  1  write-back enable
- i_wb_rd  in  5  write-back destination
- i_wb_data  in  XLEN  write-back value
- o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr, o_ctrl, o_pred_taken, o_pred_target, o_pht_idx  out  widths as inputs  registered copies

Behaviour:
- Reset (async assert, sync release on i_clk rising edge): every output 0; o_ctrl = CTRL_NOP (all-zero, no reg/mem write, no branch/jump).
- Latency: 1 cycle, ID input at edge N appears on outputs after edge N.
- Priority per rising edge: flush > stall > load.
- Flush: o_valid=0, o_ctrl=CTRL_NOP, o_pred_taken=0, all data/address fields 0. Flush with stall simultaneously = flush.
- Stall (no flush): all fields hold, except operand refresh:
  - if i_wb_we && i_wb_rd!=0 && i_wb_rd==o_rs1_addr, o_rs1_data <= i_wb_data
  - same rule independently for o_rs2_data
  - both may update in the same cycle when rs1==rs2
- Load (neither): all fields <= inputs. If i_valid=0, load as bubble (identical to flush values).
- Same-cycle write-back bypass on load: if i_wb_we && i_wb_rd!=0 && i_wb_rd==i_rs1_addr, capture i_wb_data instead of i_rs1_data; same for rs2. This covers register files without internal write-through.
- x0 is never refreshed or bypassed.
- o_imm is not modified by refresh; it is a pure pass-through of i_imm.
- Reset asserted mid-stall discards held contents immediately.

Decomposition:
- Shared package rv_pipe_pkg: ctrl_t packed struct with fields:
  - reg_write
  - mem_read
  - mem_write
  - wb_sel[1:0]
  - alu_src_a
  - alu_src_b
  - alu_op[3:0]
  - branch
  - jump
  - jalr
  - funct3[2:0]
- rv_pipe_pkg also holds the CTRL_NOP constant and the XLEN default.
- No sub-module; the per-operand select (bypass/refresh) is a function in the package reused by EX/MEM.

Test Plan:
- Reset with all inputs nonzero -> all outputs 0, o_ctrl==CTRL_NOP, o_valid=0.
- Load i_pc=0x100, i_imm=0xFFFFF800, i_valid=1, no stall/flush -> next cycle o_pc=0x100, o_imm=0xFFFFF800, o_valid=1.
- Stall 3 cycles holding rs1_addr=5, rs1_data=0x11; WB writes x5=0x22 in cycle 2 -> o_rs1_data becomes 0x22 and stays; other fields unchanged.
- Same edge: i_rs2_addr=7, i_rs2_data=0xAA, WB x7=0xBB -> o_rs2_data=0xBB; repeat with rd=x0 -> 0xAA captured.
- i_stall=1 and i_flush=1 together with valid contents -> o_valid=0, o_ctrl==CTRL_NOP, o_pred_taken=0.
- Assert i_rst_n low mid-stall between clock edges -> outputs clear without waiting for i_clk.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: the decoded control bundle,
// its bubble value, and the operand write-back forwarding select.
package rv_pipe_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
  } ctrl_t;

  // Bubble control: no register/memory write, no branch or jump.
  localparam ctrl_t CTRL_NOP = '0;

  // True when a write-back targets the given operand register; x0 never matches.
  function automatic logic wb_hit(input logic       wb_we,
                                  input logic [4:0] wb_rd,
                                  input logic [4:0] rs_addr);
    return wb_we && (wb_rd != 5'd0) && (wb_rd == rs_addr);
  endfunction

endpackage

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decode outputs with stall hold,
// flush-to-bubble, and write-back refresh/bypass of the register operands.
module id_ex_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN      = rv_pipe_pkg::XLEN,
  parameter int PHT_IDX_W = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [XLEN-1:0]      i_rs1_data,
  input  logic [XLEN-1:0]      i_rs2_data,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [4:0]           i_rs1_addr,
  input  logic [4:0]           i_rs2_addr,
  input  logic [4:0]           i_rd_addr,
  input  ctrl_t                i_ctrl,
  input  logic                 i_pred_taken,
  input  logic [XLEN-1:0]      i_pred_target,
  input  logic [PHT_IDX_W-1:0] i_pht_idx,
  input  logic                 i_wb_we,
  input  logic [4:0]           i_wb_rd,
  input  logic [XLEN-1:0]      i_wb_data,
  output logic                 o_valid,
  output logic [XLEN-1:0]      o_pc,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_rs2_data,
  output logic [XLEN-1:0]      o_imm,
  output logic [4:0]           o_rs1_addr,
  output logic [4:0]           o_rs2_addr,
  output logic [4:0]           o_rd_addr,
  output ctrl_t                o_ctrl,
  output logic                 o_pred_taken,
  output logic [XLEN-1:0]      o_pred_target,
  output logic [PHT_IDX_W-1:0] o_pht_idx
);

  logic                 r_valid_p0;
  logic [XLEN-1:0]      r_pc_p0;
  logic [XLEN-1:0]      r_rs1_data_p0;
  logic [XLEN-1:0]      r_rs2_data_p0;
  logic [XLEN-1:0]      r_imm_p0;
  logic [4:0]           r_rs1_addr_p0;
  logic [4:0]           r_rs2_addr_p0;
  logic [4:0]           r_rd_addr_p0;
  ctrl_t                r_ctrl_p0;
  logic                 r_pred_taken_p0;
  logic [XLEN-1:0]      r_pred_target_p0;
  logic [PHT_IDX_W-1:0] r_pht_idx_p0;

  logic w_bubble;
  logic w_ld_fwd1;
  logic w_ld_fwd2;
  logic w_st_fwd1;
  logic w_st_fwd2;

  // A flush, or a load of an empty ID slot, both produce a bubble.
  assign w_bubble  = i_flush || (!i_stall && !i_valid);
  // Bypass on load compares against incoming addresses; refresh on stall against held ones.
  assign w_ld_fwd1 = wb_hit(i_wb_we, i_wb_rd, i_rs1_addr);
  assign w_ld_fwd2 = wb_hit(i_wb_we, i_wb_rd, i_rs2_addr);
  assign w_st_fwd1 = wb_hit(i_wb_we, i_wb_rd, r_rs1_addr_p0);
  assign w_st_fwd2 = wb_hit(i_wb_we, i_wb_rd, r_rs2_addr_p0);

  // ID -> EX boundary: bubble > stall-with-refresh > load-with-bypass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_p0       <= 1'b0;
      r_pc_p0          <= '0;
      r_rs1_data_p0    <= '0;
      r_rs2_data_p0    <= '0;
      r_imm_p0         <= '0;
      r_rs1_addr_p0    <= '0;
      r_rs2_addr_p0    <= '0;
      r_rd_addr_p0     <= '0;
      r_ctrl_p0        <= CTRL_NOP;
      r_pred_taken_p0  <= 1'b0;
      r_pred_target_p0 <= '0;
      r_pht_idx_p0     <= '0;
    end else if (w_bubble) begin
      r_valid_p0       <= 1'b0;
      r_pc_p0          <= '0;
      r_rs1_data_p0    <= '0;
      r_rs2_data_p0    <= '0;
      r_imm_p0         <= '0;
      r_rs1_addr_p0    <= '0;
      r_rs2_addr_p0    <= '0;
      r_rd_addr_p0     <= '0;
      r_ctrl_p0        <= CTRL_NOP;
      r_pred_taken_p0  <= 1'b0;
      r_pred_target_p0 <= '0;
      r_pht_idx_p0     <= '0;
    end else if (i_stall) begin
      if (w_st_fwd1) r_rs1_data_p0 <= i_wb_data;
      if (w_st_fwd2) r_rs2_data_p0 <= i_wb_data;
    end else begin
      r_valid_p0       <= 1'b1;
      r_pc_p0          <= i_pc;
      r_rs1_data_p0    <= w_ld_fwd1 ? i_wb_data : i_rs1_data;
      r_rs2_data_p0    <= w_ld_fwd2 ? i_wb_data : i_rs2_data;
      r_imm_p0         <= i_imm;
      r_rs1_addr_p0    <= i_rs1_addr;
      r_rs2_addr_p0    <= i_rs2_addr;
      r_rd_addr_p0     <= i_rd_addr;
      r_ctrl_p0        <= i_ctrl;
      r_pred_taken_p0  <= i_pred_taken;
      r_pred_target_p0 <= i_pred_target;
      r_pht_idx_p0     <= i_pht_idx;
    end
  end

  assign o_valid       = r_valid_p0;
  assign o_pc          = r_pc_p0;
  assign o_rs1_data    = r_rs1_data_p0;
  assign o_rs2_data    = r_rs2_data_p0;
  assign o_imm         = r_imm_p0;
  assign o_rs1_addr    = r_rs1_addr_p0;
  assign o_rs2_addr    = r_rs2_addr_p0;
  assign o_rd_addr     = r_rd_addr_p0;
  assign o_ctrl        = r_ctrl_p0;
  assign o_pred_taken  = r_pred_taken_p0;
  assign o_pred_target = r_pred_target_p0;
  assign o_pht_idx     = r_pht_idx_p0;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: vector table for single-edge behaviour plus
// hand sequences for reset, multi-cycle stall refresh, stall+flush, async reset.
module tb_id_ex_reg;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid;
  logic [31:0] pc, rs1_data, rs2_data, imm, pred_target, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_rd;
  ctrl_t       ctrl;
  logic        pred_taken, wb_we;
  logic [9:0]  pht_idx;

  logic        o_valid, o_pred_taken;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm, o_pred_target;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  ctrl_t       o_ctrl;
  logic [9:0]  o_pht_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .PHT_IDX_W(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr), .i_ctrl(ctrl),
    .i_pred_taken(pred_taken), .i_pred_target(pred_target), .i_pht_idx(pht_idx),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_ctrl(o_ctrl), .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .o_pht_idx(o_pht_idx)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] pc, imm;
    logic [4:0]  rs1a; logic [31:0] rs1d;
    logic [4:0]  rs2a; logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [16:0] ctrl;
    logic        pt; logic [31:0] tgt; logic [9:0] pht;
    logic        we; logic [4:0] wrd; logic [31:0] wdata;
    logic        e_valid; logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
    logic [4:0]  e_rd; logic [16:0] e_ctrl; logic e_pt; logic [31:0] e_tgt; logic [9:0] e_pht;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; valid = v.valid;
    pc = v.pc; imm = v.imm; rs1_addr = v.rs1a; rs1_data = v.rs1d;
    rs2_addr = v.rs2a; rs2_data = v.rs2d; rd_addr = v.rd; ctrl = ctrl_t'(v.ctrl);
    pred_taken = v.pt; pred_target = v.tgt; pht_idx = v.pht;
    wb_we = v.we; wb_rd = v.wrd; wb_data = v.wdata;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, ".pc"}, o_pc, 32'd0);
    chk({tag, ".rs1"}, o_rs1_data, 32'd0);
    chk({tag, ".rs2"}, o_rs2_data, 32'd0);
    chk({tag, ".imm"}, o_imm, 32'd0);
    chk({tag, ".ctrl"}, {15'd0, o_ctrl}, {15'd0, CTRL_NOP});
    chk({tag, ".pt"}, {31'd0, o_pred_taken}, 32'd0);
    chk({tag, ".tgt"}, o_pred_target, 32'd0);
  endtask

  initial begin
    // stall,flush,valid, pc,imm, rs1a,rs1d, rs2a,rs2d, rd, ctrl, pt,tgt,pht, we,wrd,wdata,
    // e_valid,e_pc,e_rs1,e_rs2,e_imm,e_rd,e_ctrl,e_pt,e_tgt,e_pht
    vt[0] = '{0,0,1, 32'h100,32'hFFFFF800, 1,32'h1111, 2,32'h2222, 3, 17'h0A5C3, 1,32'h200,10'h155, 0,0,32'h0,
              1,32'h100,32'h1111,32'h2222,32'hFFFFF800,3,17'h0A5C3,1,32'h200,10'h155};
    vt[1] = '{0,0,1, 32'h104,32'h10, 3,32'h3333, 7,32'hAA, 8, 17'h00001, 0,32'h0,10'h0AA, 1,7,32'hBB,
              1,32'h104,32'h3333,32'hBB,32'h10,8,17'h00001,0,32'h0,10'h0AA};
    vt[2] = '{0,0,1, 32'h108,32'h20, 4,32'h4444, 0,32'hAA, 9, 17'h00002, 0,32'h0,10'h0, 1,0,32'hBB,
              1,32'h108,32'h4444,32'hAA,32'h20,9,17'h00002,0,32'h0,10'h0};
    vt[3] = '{0,0,1, 32'h10C,32'h30, 7,32'h55, 7,32'h66, 10, 17'h00003, 1,32'h400,10'h3FF, 0,7,32'hBB,
              1,32'h10C,32'h55,32'h66,32'h30,10,17'h00003,1,32'h400,10'h3FF};
    vt[4] = '{0,0,1, 32'h110,32'h40, 9,32'h1, 9,32'h2, 11, 17'h00004, 0,32'h0,10'h1, 1,9,32'hCC,
              1,32'h110,32'hCC,32'hCC,32'h40,11,17'h00004,0,32'h0,10'h1};
    vt[5] = '{1,1,1, 32'h114,32'h50, 1,32'h1, 2,32'h2, 12, 17'h1FFFF, 1,32'h500,10'h3FF, 1,1,32'hDD,
              0,32'h0,32'h0,32'h0,32'h0,0,17'h0,0,32'h0,10'h0};
    vt[6] = '{0,0,0, 32'h118,32'h60, 1,32'h1, 2,32'h2, 13, 17'h1FFFF, 1,32'h600,10'h3FF, 0,0,32'h0,
              0,32'h0,32'h0,32'h0,32'h0,0,17'h0,0,32'h0,10'h0};

    // Reset with every input nonzero
    rst_n = 1'b0;
    stall = 1; flush = 1; valid = 1; pc = '1; imm = '1; rs1_data = '1; rs2_data = '1;
    rs1_addr = 5'd3; rs2_addr = 5'd4; rd_addr = 5'd5; ctrl = ctrl_t'(17'h1FFFF);
    pred_taken = 1; pred_target = '1; pht_idx = '1; wb_we = 1; wb_rd = 5'd3; wb_data = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, each one edge
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vt[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), {31'd0, o_valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("v%0d.pc", i), o_pc, vt[i].e_pc);
      chk($sformatf("v%0d.rs1", i), o_rs1_data, vt[i].e_rs1);
      chk($sformatf("v%0d.rs2", i), o_rs2_data, vt[i].e_rs2);
      chk($sformatf("v%0d.imm", i), o_imm, vt[i].e_imm);
      chk($sformatf("v%0d.rd", i), {27'd0, o_rd_addr}, {27'd0, vt[i].e_rd});
      chk($sformatf("v%0d.ctrl", i), {15'd0, o_ctrl}, {15'd0, vt[i].e_ctrl});
      chk($sformatf("v%0d.pt", i), {31'd0, o_pred_taken}, {31'd0, vt[i].e_pt});
      chk($sformatf("v%0d.tgt", i), o_pred_target, vt[i].e_tgt);
      chk($sformatf("v%0d.pht", i), {22'd0, o_pht_idx}, {22'd0, vt[i].e_pht});
    end

    // Stall 3 cycles: refresh rs1 (x5) in cycle 2; x0 write in cycle 1 must not touch rs2 (x0)
    @(negedge clk);
    stall = 0; flush = 0; valid = 1; pc = 32'h300; imm = 32'h7; rs1_addr = 5'd5; rs1_data = 32'h11;
    rs2_addr = 5'd0; rs2_data = 32'h77; rd_addr = 5'd6; ctrl = ctrl_t'(17'h00155);
    pred_taken = 1; pred_target = 32'h340; pht_idx = 10'h2A; wb_we = 0; wb_rd = 0; wb_data = 0;
    @(posedge clk); #1;
    chk("st.load.rs1", o_rs1_data, 32'h11);
    @(negedge clk);
    stall = 1; pc = 32'hDEAD; imm = 32'hBEEF; rs1_data = 32'h99; rs2_data = 32'h98; valid = 1;
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'h99;
    @(posedge clk); #1;
    chk("st.c1.rs1", o_rs1_data, 32'h11);
    chk("st.c1.rs2_x0", o_rs2_data, 32'h77);
    @(negedge clk);
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'h22;
    @(posedge clk); #1;
    chk("st.c2.rs1", o_rs1_data, 32'h22);
    @(negedge clk);
    wb_we = 0; wb_rd = 5'd5; wb_data = 32'h33;
    @(posedge clk); #1;
    chk("st.c3.rs1", o_rs1_data, 32'h22);
    chk("st.c3.rs2", o_rs2_data, 32'h77);
    chk("st.c3.pc", o_pc, 32'h300);
    chk("st.c3.imm", o_imm, 32'h7);
    chk("st.c3.valid", {31'd0, o_valid}, 32'd1);
    chk("st.c3.ctrl", {15'd0, o_ctrl}, 32'h155);
    chk("st.c3.pht", {22'd0, o_pht_idx}, 32'h2A);

    // Stall and flush together on valid contents
    @(negedge clk);
    stall = 1; flush = 1;
    @(posedge clk); #1;
    chk_zero("stflush");

    // Async reset mid-stall, between edges
    @(negedge clk);
    stall = 0; flush = 0; valid = 1; pc = 32'h500; pred_taken = 1; ctrl = ctrl_t'(17'h00F0F);
    @(posedge clk); #1;
    chk("ar.pre.pc", o_pc, 32'h500);
    stall = 1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
